// File: rtl/discharge_pulse_scheduler_pkg.sv
// Shared types and constants for the discharge pulse scheduler.
// Holds the state encoding, bus widths and the Toff floor helper.
package discharge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_BD = 2'd1,
        ON      = 2'd2,
        OFF     = 2'd3
    } state_t;

    localparam int PARAM_W             = 16;
    localparam int CNT_W               = 32;
    localparam int EVT_W               = 16;
    localparam int DEFAULT_MIN_TOFF_US = 2;

    function automatic logic [PARAM_W-1:0] floor_toff(
        input logic [PARAM_W-1:0] toff,
        input logic [PARAM_W-1:0] min_toff
    );
        return (toff < min_toff) ? min_toff : toff;
    endfunction

endpackage

// File: rtl/discharge_pulse_scheduler_if.sv
// Parameter, gap-status and driver-command bundle of the pulse scheduler.
// The master side is the synchronizer plus gap sensing; the slave side is the scheduler.
interface discharge_pulse_scheduler_if;
    import discharge_pkg::*;

    logic               is_machine;
    logic [PARAM_W-1:0] Ton_data;
    logic [PARAM_W-1:0] Toff_data;
    logic [PARAM_W-1:0] Ip_data;
    logic [PARAM_W-1:0] waveform_data;
    logic               breakdown;
    logic               short_circuit;
    logic               gate_en;
    logic [PARAM_W-1:0] Ip_cmd;
    logic [PARAM_W-1:0] waveform_sel;
    logic [1:0]         state_o;
    logic [CNT_W-1:0]   pulse_count;
    logic [EVT_W-1:0]   timeout_count;
    logic [EVT_W-1:0]   short_count;

    modport master (
        output is_machine, Ton_data, Toff_data, Ip_data, waveform_data,
               breakdown, short_circuit,
        input  gate_en, Ip_cmd, waveform_sel, state_o,
               pulse_count, timeout_count, short_count
    );

    modport slave (
        input  is_machine, Ton_data, Toff_data, Ip_data, waveform_data,
               breakdown, short_circuit,
        output gate_en, Ip_cmd, waveform_sel, state_o,
               pulse_count, timeout_count, short_count
    );

endinterface

// File: rtl/discharge_pulse_scheduler_us_timer.sv
// Prescaler plus microsecond counter shared by all timed scheduler states.
// done fires on the last clk cycle of the target-th microsecond after a clear.
module us_timer #(
    parameter int CLK_PER_US = 100,
    parameter int W          = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] target,
    output logic         done
);
    localparam int             CYC_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_US - 1);

    logic [CYC_W-1:0] cyc_cnt;
    logic [W-1:0]     us_cnt;
    logic             tick;

    assign tick = (cyc_cnt == CYC_LAST);
    assign done = tick && (us_cnt == target - W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            us_cnt  <= '0;
        end else if (clr) begin
            cyc_cnt <= '0;
            us_cnt  <= '0;
        end else if (tick) begin
            cyc_cnt <= '0;
            us_cnt  <= us_cnt + W'(1);
        end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

endmodule

// File: rtl/discharge_pulse_scheduler.sv
// Sequences one EDM discharge pulse per period: wait for breakdown, on-time, off-time.
// Parameters are shadowed at each period start so updates never disturb a pulse in flight.
module discharge_pulse_scheduler
    import discharge_pkg::*;
#(
    parameter int CLK_PER_US      = 100,
    parameter int WAIT_TIMEOUT_US = 1000,
    parameter int MIN_TOFF_US     = DEFAULT_MIN_TOFF_US
) (
    input logic                         clk,
    input logic                         rst,
    discharge_pulse_scheduler_if.slave  bus
);
    state_t             state;
    logic [PARAM_W-1:0] ton_s, toff_s, ip_s, wf_s;
    logic [PARAM_W-1:0] target;
    logic [PARAM_W-1:0] ip_cmd;
    logic [CNT_W-1:0]   pulse_cnt;
    logic [EVT_W-1:0]   timeout_cnt, short_cnt;
    logic               gate_en, can_start, leave, latch, tmr_done, tmr_clr;

    assign can_start = bus.is_machine && (bus.Ton_data != '0);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        target = '0;
        leave  = 1'b0;
        case (state)
            IDLE:    leave = can_start;
            WAIT_BD: begin
                target = PARAM_W'(WAIT_TIMEOUT_US);
                leave  = bus.short_circuit || !bus.is_machine || bus.breakdown || tmr_done;
            end
            ON: begin
                target = ton_s;
                leave  = bus.short_circuit || !bus.is_machine || tmr_done;
            end
            OFF: begin
                target = toff_s;
                leave  = tmr_done;
            end
            default: leave = 1'b0;
        endcase
    end

    // Every transition is a state entry, so leaving a state is what restarts the timer.
    assign tmr_clr = leave || (state == IDLE);
    assign latch   = can_start && ((state == IDLE) || ((state == OFF) && tmr_done));

    us_timer #(.CLK_PER_US(CLK_PER_US), .W(PARAM_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .target (target),
        .done   (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ton_s  <= '0;
            toff_s <= '0;
            ip_s   <= '0;
            wf_s   <= '0;
        end else if (latch) begin
            ton_s  <= bus.Ton_data;
            toff_s <= floor_toff(bus.Toff_data, PARAM_W'(MIN_TOFF_US));
            ip_s   <= bus.Ip_data;
            wf_s   <= bus.waveform_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gate_en     <= 1'b0;
            ip_cmd      <= '0;
            pulse_cnt   <= '0;
            timeout_cnt <= '0;
            short_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (can_start) begin
                    state   <= WAIT_BD;
                    gate_en <= 1'b1;
                end
                WAIT_BD: begin
                    if (bus.short_circuit) begin
                        state   <= OFF;
                        gate_en <= 1'b0;
                        if (short_cnt != '1) short_cnt <= short_cnt + EVT_W'(1);
                    end else if (!bus.is_machine) begin
                        state   <= OFF;
                        gate_en <= 1'b0;
                    end else if (bus.breakdown) begin
                        state  <= ON;
                        ip_cmd <= ip_s;
                    end else if (tmr_done) begin
                        state   <= OFF;
                        gate_en <= 1'b0;
                        if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + EVT_W'(1);
                    end
                end
                ON: if (leave) begin
                    state   <= OFF;
                    gate_en <= 1'b0;
                    ip_cmd  <= '0;
                    if (bus.short_circuit) begin
                        if (short_cnt != '1) short_cnt <= short_cnt + EVT_W'(1);
                    end else if (bus.is_machine && pulse_cnt != '1) begin
                        pulse_cnt <= pulse_cnt + CNT_W'(1);
                    end
                end
                OFF: if (tmr_done) begin
                    state   <= can_start ? WAIT_BD : IDLE;
                    gate_en <= can_start;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gate_en       = gate_en;
    assign bus.Ip_cmd        = ip_cmd;
    assign bus.waveform_sel  = wf_s;
    assign bus.state_o       = state;
    assign bus.pulse_count   = pulse_cnt;
    assign bus.timeout_count = timeout_cnt;
    assign bus.short_count   = short_cnt;

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// Self-checking bench for discharge_pulse_scheduler with randomized pulse parameters.
// Expected dwell times and counter values come from the timing rules in plain arithmetic.
module tb_discharge_pulse_scheduler;
    localparam int CPU      = 4;
    localparam int TMO      = 10;
    localparam int MIN_TOFF = 2;
    localparam int BUDGET   = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp_count = 0;
    int   bad_count = 0;
    int   exp_pulse, exp_timeout, exp_short;

    discharge_pulse_scheduler_if bus();

    discharge_pulse_scheduler #(.CLK_PER_US(CPU), .WAIT_TIMEOUT_US(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int off_cycles(input int toff);
        return ((toff < MIN_TOFF) ? MIN_TOFF : toff) * CPU;
    endfunction

    task automatic drive_quiet();
        bus.is_machine    = 1'b0;
        bus.Ton_data      = '0;
        bus.Toff_data     = '0;
        bus.Ip_data       = '0;
        bus.waveform_data = '0;
        bus.breakdown     = 1'b0;
        bus.short_circuit = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pulse = 0; exp_timeout = 0; exp_short = 0;
    endtask

    // Counts cycles spent in state s, starting at the current (first) negedge in it.
    task automatic count_dwell(input logic [1:0] s, output int n);
        n = 0;
        while (bus.state_o === s && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic start(input int ton, input int toff, input logic [15:0] ip, input logic [15:0] wf);
        bus.Ton_data = 16'(ton); bus.Toff_data = 16'(toff);
        bus.Ip_data = ip; bus.waveform_data = wf; bus.is_machine = 1'b1;
        @(negedge clk);
    endtask

    task automatic breakdown_after(input int d);
        repeat (d - 1) @(negedge clk);
        bus.breakdown = 1'b1;
        @(negedge clk);
        bus.breakdown = 1'b0;
    endtask

    task automatic test_reset();
        drive_quiet();
        bus.Ip_data = 16'hBEEF; bus.waveform_data = 16'h1234;
        apply_reset();
        cmp_count++; if (bus.state_o !== 2'd0) begin bad_count++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
        cmp_count++; if (bus.gate_en !== 1'b0) begin bad_count++; $display("FAIL reset_gate: got %b want 0", bus.gate_en); end
        cmp_count++; if (bus.Ip_cmd !== 16'd0) begin bad_count++; $display("FAIL reset_ip: got %0d want 0", bus.Ip_cmd); end
        cmp_count++; if (bus.waveform_sel !== 16'd0) begin bad_count++; $display("FAIL reset_wf: got %0d want 0", bus.waveform_sel); end
        cmp_count++; if ({bus.pulse_count, bus.timeout_count, bus.short_count} !== 64'd0) begin bad_count++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", bus.pulse_count, bus.timeout_count, bus.short_count); end
    endtask

    task automatic test_back_to_back();
        int ton, toff, d, n;
        logic [15:0] ip, wf;
        drive_quiet();
        apply_reset();
        ton = $urandom_range(1, 5); toff = $urandom_range(0, 5);
        ip = 16'($urandom_range(1, 65535)); wf = 16'($urandom_range(0, 65535));
        start(ton, toff, ip, wf);
        for (int i = 0; i < 5; i++) begin
            cmp_count++; if (bus.state_o !== 2'd1 || bus.gate_en !== 1'b1 || bus.Ip_cmd !== 16'd0) begin bad_count++; $display("FAIL b2b_wait[%0d]: state=%0d gate=%b ip=%0d want 1/1/0", i, bus.state_o, bus.gate_en, bus.Ip_cmd); end
            cmp_count++; if (bus.waveform_sel !== wf) begin bad_count++; $display("FAIL b2b_wf[%0d]: got %0d want %0d", i, bus.waveform_sel, wf); end
            d = $urandom_range(1, 8);
            breakdown_after(d);
            cmp_count++; if (bus.state_o !== 2'd2 || bus.Ip_cmd !== ip) begin bad_count++; $display("FAIL b2b_on[%0d]: state=%0d ip=%0d want 2/%0d", i, bus.state_o, bus.Ip_cmd, ip); end
            count_dwell(2'd2, n);
            cmp_count++; if (n !== ton * CPU) begin bad_count++; $display("FAIL b2b_on_len[%0d]: got %0d want %0d", i, n, ton * CPU); end
            exp_pulse++;
            cmp_count++; if (bus.gate_en !== 1'b0 || bus.pulse_count !== 32'(exp_pulse)) begin bad_count++; $display("FAIL b2b_off[%0d]: gate=%b pulses=%0d want 0/%0d", i, bus.gate_en, bus.pulse_count, exp_pulse); end
            // New parameters appear mid-OFF; they must only take effect at the next period.
            bus.Ton_data = 16'($urandom_range(1, 5)); bus.Toff_data = 16'($urandom_range(0, 5));
            bus.Ip_data = 16'($urandom_range(1, 65535)); bus.waveform_data = 16'($urandom_range(0, 65535));
            @(negedge clk);
            cmp_count++; if (bus.waveform_sel !== wf) begin bad_count++; $display("FAIL b2b_wf_hold[%0d]: got %0d want %0d", i, bus.waveform_sel, wf); end
            count_dwell(2'd3, n);
            cmp_count++; if (n + 1 !== off_cycles(toff)) begin bad_count++; $display("FAIL b2b_off_len[%0d]: got %0d want %0d", i, n + 1, off_cycles(toff)); end
            ton = int'(bus.Ton_data); toff = int'(bus.Toff_data); ip = bus.Ip_data; wf = bus.waveform_data;
        end
    endtask

    task automatic test_timeout();
        int n;
        drive_quiet();
        apply_reset();
        start(3, $urandom_range(0, 4), 16'd77, 16'd5);
        count_dwell(2'd1, n);
        exp_timeout++;
        cmp_count++; if (n !== TMO * CPU) begin bad_count++; $display("FAIL timeout_len: got %0d want %0d", n, TMO * CPU); end
        cmp_count++; if (bus.state_o !== 2'd3 || bus.gate_en !== 1'b0) begin bad_count++; $display("FAIL timeout_off: state=%0d gate=%b want 3/0", bus.state_o, bus.gate_en); end
        cmp_count++; if (bus.timeout_count !== 16'(exp_timeout) || bus.pulse_count !== 32'(exp_pulse)) begin bad_count++; $display("FAIL timeout_counts: timeouts=%0d pulses=%0d want %0d/%0d", bus.timeout_count, bus.pulse_count, exp_timeout, exp_pulse); end
    endtask

    task automatic test_short();
        int ton, n;
        drive_quiet();
        apply_reset();
        ton = $urandom_range(1, 4);
        start(ton, $urandom_range(0, 3), 16'd999, 16'd3);
        repeat ($urandom_range(0, 6)) @(negedge clk);
        bus.breakdown = 1'b1; bus.short_circuit = 1'b1;
        @(negedge clk);
        bus.breakdown = 1'b0; bus.short_circuit = 1'b0;
        exp_short++;
        cmp_count++; if (bus.state_o !== 2'd3 || bus.Ip_cmd !== 16'd0) begin bad_count++; $display("FAIL short_bd: state=%0d ip=%0d want 3/0", bus.state_o, bus.Ip_cmd); end
        cmp_count++; if (bus.short_count !== 16'(exp_short)) begin bad_count++; $display("FAIL short_bd_count: got %0d want %0d", bus.short_count, exp_short); end
        count_dwell(2'd3, n);
        breakdown_after(1);
        // Short lands on the very edge the on-time expires: it must win.
        repeat (ton * CPU - 1) @(negedge clk);
        bus.short_circuit = 1'b1;
        @(negedge clk);
        bus.short_circuit = 1'b0;
        exp_short++;
        cmp_count++; if (bus.state_o !== 2'd3 || bus.pulse_count !== 32'(exp_pulse)) begin bad_count++; $display("FAIL short_on_done: state=%0d pulses=%0d want 3/%0d", bus.state_o, bus.pulse_count, exp_pulse); end
        cmp_count++; if (bus.short_count !== 16'(exp_short)) begin bad_count++; $display("FAIL short_on_count: got %0d want %0d", bus.short_count, exp_short); end
    endtask

    task automatic test_ton_change();
        int n;
        drive_quiet();
        apply_reset();
        start(3, 5, 16'd10, 16'd1);
        breakdown_after(1);
        repeat (5) @(negedge clk);
        bus.Ton_data = 16'd7;
        count_dwell(2'd2, n);
        cmp_count++; if (n + 5 !== 12) begin bad_count++; $display("FAIL ton_inflight: got %0d want 12", n + 5); end
        count_dwell(2'd3, n);
        breakdown_after(1);
        count_dwell(2'd2, n);
        cmp_count++; if (n !== 28) begin bad_count++; $display("FAIL ton_next: got %0d want 28", n); end
    endtask

    task automatic test_min_toff_and_zero_ton();
        int n;
        drive_quiet();
        apply_reset();
        start(1, 0, 16'd4, 16'd2);
        breakdown_after(1);
        count_dwell(2'd2, n);
        count_dwell(2'd3, n);
        cmp_count++; if (n !== MIN_TOFF * CPU) begin bad_count++; $display("FAIL min_toff: got %0d want %0d", n, MIN_TOFF * CPU); end
        drive_quiet();
        apply_reset();
        bus.is_machine = 1'b1;
        repeat (20) @(negedge clk);
        cmp_count++; if (bus.state_o !== 2'd0 || bus.gate_en !== 1'b0) begin bad_count++; $display("FAIL zero_ton: state=%0d gate=%b want 0/0", bus.state_o, bus.gate_en); end
    endtask

    task automatic test_machine_drop_and_reset();
        int ton, toff, n;
        drive_quiet();
        apply_reset();
        ton = $urandom_range(2, 5); toff = $urandom_range(0, 5);
        start(ton, toff, 16'd321, 16'($urandom_range(1, 65535)));
        breakdown_after(1);
        repeat ($urandom_range(1, ton * CPU - 2)) @(negedge clk);
        bus.is_machine = 1'b0;
        @(negedge clk);
        cmp_count++; if (bus.state_o !== 2'd3 || bus.gate_en !== 1'b0 || bus.pulse_count !== 32'(exp_pulse)) begin bad_count++; $display("FAIL drop_off: state=%0d gate=%b pulses=%0d want 3/0/%0d", bus.state_o, bus.gate_en, bus.pulse_count, exp_pulse); end
        count_dwell(2'd3, n);
        cmp_count++; if (n !== off_cycles(toff)) begin bad_count++; $display("FAIL drop_toff: got %0d want %0d", n, off_cycles(toff)); end
        cmp_count++; if (bus.state_o !== 2'd0) begin bad_count++; $display("FAIL drop_idle: got %0d want 0", bus.state_o); end
        // A completed pulse, then reset asynchronously in the middle of OFF.
        start(ton, 5, 16'd321, 16'hA5A5);
        breakdown_after(2);
        count_dwell(2'd2, n);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        cmp_count++; if (bus.state_o !== 2'd0 || bus.gate_en !== 1'b0 || bus.Ip_cmd !== 16'd0 || bus.waveform_sel !== 16'd0) begin bad_count++; $display("FAIL rst_midoff: state=%0d gate=%b ip=%0d wf=%0d want 0/0/0/0", bus.state_o, bus.gate_en, bus.Ip_cmd, bus.waveform_sel); end
        cmp_count++; if ({bus.pulse_count, bus.timeout_count, bus.short_count} !== 64'd0) begin bad_count++; $display("FAIL rst_midoff_counts: got %0d/%0d/%0d want 0/0/0", bus.pulse_count, bus.timeout_count, bus.short_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive_quiet();
        test_reset();
        test_back_to_back();
        test_timeout();
        test_short();
        test_ton_change();
        test_min_toff_and_zero_ton();
        test_machine_drop_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, bad_count);
        $finish;
    end

endmodule

// File: doc/discharge_pulse_scheduler.md
# discharge_pulse_scheduler

Sequences each discharge pulse from the synchronized pulse parameters (is_machine, Ton, Toff, Ip, waveform). The sequence is: wait for gap breakdown, hold on-time, then enforce off-time. It sits between the parameter synchronizer and the gate/current drivers. Parameters are latched into shadow registers once per pulse period, so SPI updates never alter a pulse in flight.

## Interface
- CLK_PER_US, 100: clk cycles per µs timing tick
- WAIT_TIMEOUT_US, 1000: max µs in WAIT_BD before forced OFF
- MIN_TOFF_US, 2: floor applied to latched Toff
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- is_machine  in  1  machining enable, already synchronized to clk
- Ton_data  in  16  on-time, µs
- Toff_data  in  16  off-time, µs
- Ip_data  in  16  peak-current command
- waveform_data  in  16  waveform select
- breakdown  in  1  gap breakdown detected, synchronized
- short_circuit  in  1  gap short detected, synchronized
- gate_en  out  1  main switch gate enable
- Ip_cmd  out  16  current command to driver
- waveform_sel  out  16  latched waveform select
- state_o  out  2  current state
- pulse_count  out  32  completed ON pulses, saturating
- timeout_count  out  16  WAIT_BD timeouts, saturating
- short_count  out  16  short-circuit aborts, saturating

## Operation
- States: IDLE=0, WAIT_BD=1, ON=2, OFF=3.
- Latch event: copy Ton_s←Ton_data, Toff_s←max(Toff_data, MIN_TOFF_US), Ip_s←Ip_data, wf_s←waveform_data.
- IDLE:
  - gate_en=0, Ip_cmd=0.
  - If is_machine=1 and Ton_data≠0: latch, then go to WAIT_BD.
  - If Ton_data=0: stay in IDLE.
- WAIT_BD:
  - gate_en=1, Ip_cmd=0.
  - Exits, in priority order: short_circuit→OFF (short_count++); is_machine=0→OFF; breakdown→ON; timer reaches WAIT_TIMEOUT_US→OFF (timeout_count++).
- ON:
  - gate_en=1, Ip_cmd=Ip_s.
  - short_circuit→OFF (short_count++, pulse not counted).
  - is_machine=0→OFF.
  - Timer reaches Ton_s→OFF, pulse_count++.
- OFF:
  - gate_en=0, Ip_cmd=0.
  - Always runs the full Toff_s.
  - Timer reaches Toff_s with is_machine=1 and Ton_data≠0: latch, then go to WAIT_BD. Otherwise go to IDLE.
- waveform_sel=wf_s at all times; it changes only on a latch event.
- Counters saturate at all-ones and never wrap.

## Timing
- All outputs are registered. gate_en, Ip_cmd and state_o update on the same edge as the state change.
- Timer clears on every state entry.
- A target of N µs means the state lasts exactly N·CLK_PER_US cycles. Transition occurs on the edge where us_cnt=N−1 and cyc_cnt=CLK_PER_US−1.
- breakdown or short_circuit sampled high at edge k gives the new state at edge k (one cycle after the input rises).
- Reset mid-operation: immediate IDLE. gate_en=0, Ip_cmd=0, waveform_sel=0, state_o=0, all counters=0, shadows=0.
- Parameter changes outside a latch event have no effect until the next latch.
- Simultaneous short_circuit and breakdown in WAIT_BD: short wins.
- Simultaneous timer-done and short_circuit in ON: short wins, pulse not counted.

## Structure
- Shared package discharge_pkg holds:
  - state encoding enum
  - width constants (PARAM_W=16, CNT_W=32)
  - default MIN_TOFF_US
- Sub-module us_timer contains the prescaler plus µs counter. Inputs: clr, target. Output: done pulse. Instantiated once and shared by all timed states.

## Test plan
All scenarios use CLK_PER_US=4 and WAIT_TIMEOUT_US=10.
- Ton=3, Toff=5, is_machine=1, breakdown 2 cycles after entering WAIT_BD → gate_en high 2+12 cycles, then low for exactly 20 cycles; pulse_count=1; re-enters WAIT_BD.
- No breakdown → WAIT_BD lasts 40 cycles, then OFF; timeout_count=1; pulse_count=0.
- short_circuit and breakdown asserted in the same cycle during WAIT_BD → OFF; short_count=1; Ip_cmd stays 0.
- Ton changed 3→7 mid-ON → current pulse stays 12 cycles; next ON lasts 28 cycles.
- Toff_data=0 → OFF lasts 8 cycles (MIN_TOFF). Ton_data=0 with is_machine=1 → stays IDLE.
- is_machine drops mid-ON → OFF on next edge, full Toff runs, then IDLE. rst pulsed mid-OFF → all outputs 0 immediately.
